oled_frame_source_mux: RTL and testbench
========================================

# oled_frame_source_mux

Parametrised successor to the OLED state-to-pixel selector. Selects one of `NUM_SRC` pixel sources by machine state, registers the pixel output, and defers every source change to an OLED frame boundary. An optional run of blanked frames is inserted between the old and new source, so a state change never tears mid-frame. Sits between the per-state screen generators and the OLED display driver.

## Interface
- `NUM_SRC`, default 9: number of pixel sources.
- `PIX_W`, default 16: pixel width (RGB565).
- `SEL_W`, default 4: selector width; must satisfy 2^SEL_W ≥ NUM_SRC.
- `BLANK_FRAMES`, default 1: whole frames of `BLANK_COLOR` inserted on a switch; 0 means a direct switch at the frame boundary.
- `BLANK_COLOR`, default 16'h0000: colour for blank frames, disabled sources and out-of-range selects.
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `sel` in SEL_W: requested source (machine state).
- `src_en` in NUM_SRC: per-source enable; a disabled source shows `BLANK_COLOR`.
- `src_data` in NUM_SRC*PIX_W: packed sources; source i is at bits [i*PIX_W +: PIX_W].
- `frame_begin` in 1: single-cycle pulse from the display driver when pixel index wraps to 0.
- `oled_data` out PIX_W: registered pixel to the driver.
- `active_sel` out SEL_W: source currently committed.
- `switching` out 1: high while a change is pending or blanking.

## Operation
- Reset values: state SHOW, `active_sel`=0, `pending_sel`=0, `blank_cnt`=0, `oled_data`=0, `switching`=0.
- SHOW:
  - `oled_data` ← source `active_sel`.
  - If `sel`≠`active_sel`, latch `pending_sel`=`sel` and go to WAIT_EOF.
- WAIT_EOF:
  - Still shows the old source. `pending_sel` tracks `sel` every cycle.
  - If `sel`==`active_sel`, cancel and return to SHOW with no blanking.
  - On `frame_begin` with `BLANK_FRAMES`=0: commit `active_sel`=`pending_sel` and go to SHOW.
  - On `frame_begin` with `BLANK_FRAMES`>0: `blank_cnt`=`BLANK_FRAMES` and go to BLANK.
- BLANK:
  - `oled_data` ← `BLANK_COLOR`. `pending_sel` keeps tracking `sel`; a change of `sel` here does not cancel or restart the blanking.
  - Each `frame_begin` decrements `blank_cnt`. The `frame_begin` at `blank_cnt`==1 commits `pending_sel` and returns to SHOW.
  - A `sel` equal to the old `active_sel` is still committed after the blanking.
- Source resolution: `sel` ≥ `NUM_SRC`, or `src_en[sel]`==0, yields `BLANK_COLOR`. This resolution is evaluated every cycle, not latched.
- `switching` = (state ≠ SHOW), registered with the state.
- `frame_begin` in SHOW with no request pending: no effect.

## Timing
- `oled_data` has 1 cycle latency from `src_data`, `src_en` and the state. It is registered, with no combinational path to the output.
- A commit takes effect on the `frame_begin` cycle. The new source appears on `oled_data` in the cycle after `frame_begin`, i.e. pixel 0 of the new frame, assuming the driver samples 1 cycle after the index.
- Blank window is exactly `BLANK_FRAMES` full frames.
- Total switch latency is the time to the next `frame_begin` plus `BLANK_FRAMES` frames.
- `sel` and `frame_begin` in the same cycle while in SHOW: the request is latched and that `frame_begin` is not used. The switch waits for the next frame.
- `rst_n` deasserted mid-blank or mid-wait: immediate return to reset values. Output goes to 0 asynchronously.
- `blank_cnt` width is $clog2(`BLANK_FRAMES`+1), minimum 1. It never wraps.

## Structure
- Shared package `oled_pkg`:
  - `OLED_PIX_W`=16
  - `OLED_W`=96, `OLED_H`=64, `OLED_FRAME_PIXELS`=6144
  - `OLED_BLACK`=16'h0000
  - state enum `mux_state_t` {SHOW, WAIT_EOF, BLANK}
- One sub-module, `oled_src_select`: combinational indexed extraction plus the enable and range check. The FSM and output register stay in the top module.

## Test plan
- **Reset:** hold `rst_n`=0 with src0=16'hF800 → `oled_data`=0, `active_sel`=0. Release → 16'hF800 one cycle later.
- **Blanked switch:** `BLANK_FRAMES`=1; `sel` 0→7 mid-frame, src7=16'h07E0 → output stays 16'hF800 until `frame_begin`, then 16'h0000 for one full frame, then 16'h07E0 from the next frame; `switching` high throughout.
- **Cancel:** `sel` 0→3→0 before any `frame_begin` → no blank frame, `active_sel` stays 0, `switching` pulses only while the request was pending.
- **Retarget during blank:** `BLANK_FRAMES`=2; `sel`=2 → blank begins; `sel`=5 during frame 1 of the blank → exactly 2 blank frames, then source 5 is committed.
- **Disabled and out of range:** `src_en[4]`=0 with `sel`=4, then `sel`=12 (`NUM_SRC`=9) → `BLANK_COLOR` after the commit, and `active_sel` reports 4, then 12.
- **Asynchronous reset mid-BLANK:** assert `rst_n` low between clock edges → `oled_data`=0 immediately; on release, state SHOW with `active_sel`=0.

Source files
------------

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared OLED geometry, colour and mux state definitions
package oled_pkg;

  localparam int OLED_PIX_W        = 16;
  localparam int OLED_W            = 96;
  localparam int OLED_H            = 64;
  localparam int OLED_FRAME_PIXELS = OLED_W * OLED_H;

  localparam logic [OLED_PIX_W-1:0] OLED_BLACK = 16'h0000;

  typedef enum logic [1:0] {
    SHOW,
    WAIT_EOF,
    BLANK
  } mux_state_t;

endpackage

// File: rtl/oled_src_select.sv
// rtl/oled_src_select.sv - combinational pixel source extraction with enable and range check
module oled_src_select #(
  parameter int                NUM_SRC     = 9,
  parameter int                PIX_W       = 16,
  parameter int                SEL_W       = 4,
  parameter logic [PIX_W-1:0]  BLANK_COLOR = '0
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic [NUM_SRC*PIX_W-1:0] src_data,
  output logic [PIX_W-1:0]         pix
);

  // Selects beyond NUM_SRC never match an index, so they fall through to the blank colour.
  always_comb begin
    pix = BLANK_COLOR;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i) && src_en[i]) begin
        pix = src_data[i*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/oled_frame_source_mux.sv
// rtl/oled_frame_source_mux.sv - state-driven pixel source mux with frame-aligned, optionally blanked switching
module oled_frame_source_mux
  import oled_pkg::*;
#(
  parameter int                NUM_SRC      = 9,
  parameter int                PIX_W        = OLED_PIX_W,
  parameter int                SEL_W        = 4,
  parameter int                BLANK_FRAMES = 1,
  parameter logic [PIX_W-1:0]  BLANK_COLOR  = OLED_BLACK
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC-1:0]       src_en,
  input  logic [NUM_SRC*PIX_W-1:0] src_data,
  input  logic                     frame_begin,
  output logic [PIX_W-1:0]         oled_data,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     switching
);

  localparam int CNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  mux_state_t       state, state_nx;
  logic [SEL_W-1:0] active_nx;
  logic [SEL_W-1:0] pending_sel, pending_nx;
  logic [CNT_W-1:0] blank_cnt, cnt_nx;
  logic [PIX_W-1:0] src_pix;
  logic [PIX_W-1:0] pix_nx;

  // Resolve against the post-commit selection so the new source lands on pixel 0.
  oled_src_select #(
    .NUM_SRC     (NUM_SRC),
    .PIX_W       (PIX_W),
    .SEL_W       (SEL_W),
    .BLANK_COLOR (BLANK_COLOR)
  ) u_src_select (
    .sel      (active_nx),
    .src_en   (src_en),
    .src_data (src_data),
    .pix      (src_pix)
  );

  always_comb begin
    state_nx   = state;
    active_nx  = active_sel;
    pending_nx = pending_sel;
    cnt_nx     = blank_cnt;
    case (state)
      SHOW: begin
        if (sel != active_sel) begin
          pending_nx = sel;
          state_nx   = WAIT_EOF;
        end
      end
      WAIT_EOF: begin
        pending_nx = sel;
        if (sel == active_sel) begin
          state_nx = SHOW;
        end else if (frame_begin) begin
          if (BLANK_FRAMES == 0) begin
            active_nx = pending_sel;
            state_nx  = SHOW;
          end else begin
            cnt_nx   = CNT_W'(BLANK_FRAMES);
            state_nx = BLANK;
          end
        end
      end
      BLANK: begin
        pending_nx = sel;
        if (frame_begin) begin
          if (blank_cnt == CNT_W'(1)) begin
            active_nx = pending_sel;
            cnt_nx    = '0;
            state_nx  = SHOW;
          end else begin
            cnt_nx = blank_cnt - CNT_W'(1);
          end
        end
      end
      default: state_nx = SHOW;
    endcase
    pix_nx = (state_nx == BLANK) ? BLANK_COLOR : src_pix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SHOW;
      active_sel  <= '0;
      pending_sel <= '0;
      blank_cnt   <= '0;
      oled_data   <= '0;
      switching   <= 1'b0;
    end else begin
      state       <= state_nx;
      active_sel  <= active_nx;
      pending_sel <= pending_nx;
      blank_cnt   <= cnt_nx;
      oled_data   <= pix_nx;
      switching   <= (state_nx != SHOW);
    end
  end

endmodule

// File: tb/tb_oled_frame_source_mux.sv
// tb/tb_oled_frame_source_mux.sv - scoreboard bench for oled_frame_source_mux with 0, 1 and 2 blank frames
module tb_oled_frame_source_mux;
  import oled_pkg::*;

  localparam int NS        = 9;
  localparam int PW        = 16;
  localparam int SW        = 4;
  localparam int ND        = 3;
  localparam int FRAME_LEN = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SW-1:0]     sel = '0;
  logic [NS-1:0]     src_en = '1;
  logic [NS*PW-1:0]  src_data = '0;
  logic              frame_begin = 1'b0;
  logic [PW-1:0]     oled [ND];
  logic [SW-1:0]     act [ND];
  logic              sw [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    oled_frame_source_mux #(
      .NUM_SRC      (NS),
      .PIX_W        (PW),
      .SEL_W        (SW),
      .BLANK_FRAMES (g),
      .BLANK_COLOR  ((g == 1) ? 16'h0000 : 16'h001F)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sel         (sel),
      .src_en      (src_en),
      .src_data    (src_data),
      .frame_begin (frame_begin),
      .oled_data   (oled[g]),
      .active_sel  (act[g]),
      .switching   (sw[g])
    );
  end

  typedef struct packed {
    logic [15:0] oled;
    logic [3:0]  act;
    logic        sw;
  } exp_t;
  typedef struct {
    exp_t e [ND];
  } vec_t;

  vec_t sb [$];
  vec_t mon_v;
  int   vectors = 0;
  int   miscompares = 0;
  int   pix_cnt = 0;
  bit   rnd_data = 0;

  // Reference: committed source, request-in-flight flag, requested source, blank frames left.
  int m_active [ND];
  int m_pend [ND];
  int m_left [ND];
  bit m_wait [ND];

  function automatic logic [15:0] blank_of(int d);
    return (d == 1) ? 16'h0000 : 16'h001F;
  endfunction

  function automatic logic [15:0] source_pixel(int d, int idx);
    if (idx >= NS || !src_en[idx]) return blank_of(d);
    return src_data[idx*PW +: PW];
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp_v);
    vectors++;
    if (got !== exp_v) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_active[d] = 0;
      m_pend[d]   = 0;
      m_left[d]   = 0;
      m_wait[d]   = 0;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_v = sb.pop_front();
      for (int d = 0; d < ND; d++) begin
        check($sformatf("oled_data[%0d]", d), 32'(oled[d]), 32'(mon_v.e[d].oled));
        check($sformatf("active_sel[%0d]", d), 32'(act[d]), 32'(mon_v.e[d].act));
        check($sformatf("switching[%0d]", d), 32'(sw[d]), 32'(mon_v.e[d].sw));
      end
    end
  end

  task automatic step();
    vec_t v;
    int   s;
    int   prev;
    frame_begin = (pix_cnt == 0);
    if (rnd_data) begin
      for (int i = 0; i < NS; i++) src_data[i*PW +: PW] = 16'($urandom);
    end
    s = int'(sel);
    for (int d = 0; d < ND; d++) begin
      prev = m_pend[d];
      if (!m_wait[d] && m_left[d] == 0) begin
        if (s != m_active[d]) begin
          m_wait[d] = 1;
          m_pend[d] = s;
        end
      end else if (m_wait[d]) begin
        m_pend[d] = s;
        if (s == m_active[d]) begin
          m_wait[d] = 0;
        end else if (frame_begin) begin
          m_wait[d] = 0;
          if (d == 0) m_active[d] = prev;
          else        m_left[d] = d;
        end
      end else begin
        m_pend[d] = s;
        if (frame_begin) begin
          m_left[d]--;
          if (m_left[d] == 0) m_active[d] = prev;
        end
      end
      v.e[d].oled = (m_left[d] > 0) ? blank_of(d) : source_pixel(d, m_active[d]);
      v.e[d].act  = 4'(m_active[d]);
      v.e[d].sw   = m_wait[d] || (m_left[d] > 0);
    end
    @(posedge clk);
    sb.push_back(v);
    pix_cnt = (pix_cnt + 1) % FRAME_LEN;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align(input int p);
    while (pix_cnt != p) step();
  endtask

  initial begin
    for (int i = 0; i < NS; i++) src_data[i*PW +: PW] = 16'(i * 16'h1111);
    src_data[0*PW +: PW] = 16'hF800;
    src_data[7*PW +: PW] = 16'h07E0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check("reset_oled", 32'(oled[d]), 32'h0);
      check("reset_active", 32'(act[d]), 32'h0);
      check("reset_switching", 32'(sw[d]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run(3);
    check("release_oled", 32'(oled[1]), 32'hF800);

    // Blanked switch 0 -> 7 mid-frame
    align(4);
    sel = 4'd7;
    run(40);
    check("switch_active", 32'(act[1]), 32'd7);
    check("switch_oled", 32'(oled[1]), 32'h07E0);

    // Cancel 7 -> 3 -> 7 before any frame_begin
    align(2);
    sel = 4'd3;
    step();
    check("cancel_pending", 32'(sw[1]), 32'h1);
    run(2);
    sel = 4'd7;
    run(2);
    check("cancel_active", 32'(act[1]), 32'd7);
    check("cancel_switching", 32'(sw[1]), 32'h0);

    // Retarget during the first of two blank frames
    align(4);
    sel = 4'd2;
    run(14);
    check("retarget_blank", 32'(oled[2]), 32'h001F);
    sel = 4'd5;
    run(40);
    check("retarget_active", 32'(act[2]), 32'd5);

    // Disabled source then out-of-range select
    src_en[4] = 1'b0;
    sel = 4'd4;
    run(40);
    check("disabled_active", 32'(act[1]), 32'd4);
    check("disabled_oled", 32'(oled[1]), 32'h0000);
    sel = 4'd12;
    run(40);
    check("range_active", 32'(act[2]), 32'd12);
    check("range_oled", 32'(oled[2]), 32'h001F);
    src_en = '1;

    // Asynchronous reset in the middle of a blank window
    align(3);
    sel = 4'd1;
    run(15);
    check("preblank_switching", 32'(sw[2]), 32'h1);
    check("preblank_oled", 32'(oled[2]), 32'h001F);
    #5;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      check("async_oled", 32'(oled[d]), 32'h0);
      check("async_active", 32'(act[d]), 32'h0);
      check("async_switching", 32'(sw[d]), 32'h0);
    end
    repeat (2) @(posedge clk);
    model_reset();
    sel = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // Randomized traffic
    rnd_data = 1;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0) sel = 4'($urandom_range(0, 15));
      src_en = NS'(~($urandom & $urandom & $urandom));
      step();
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
